// File: rtl/chime_sequencer.sv
// Two-note "ding-dong" chime: picks N_CH-way sources per note, holds each HOLD cycles, delays DELAY cycles.
// Define CHIME_RETRIGGER_EN to let a press during DONG restart the sequence with freshly latched selects.
module chime_sequencer #(
  parameter int N_CH  = 4,
  parameter int W     = 8,
  parameter int HOLD  = 16,
  parameter int DELAY = 5,
  localparam int SW   = $clog2(N_CH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [N_CH*W-1:0] snd,
  input  logic [SW-1:0]     sel_ding,
  input  logic [SW-1:0]     sel_dong,
  input  logic              press,
  output logic              busy,
  output logic [W-1:0]      out,
  output logic              out_valid
);

  // state | meaning
  // IDLE  | waiting for press, raw output silent
  // DING  | playing first note (latched sel_ding) for HOLD cycles
  // DONG  | playing second note (latched sel_dong) for HOLD cycles
  typedef enum logic [1:0] {IDLE, DING, DONG} state_t;

  localparam int CW = (HOLD > 1) ? $clog2(HOLD) : 1;
  localparam logic [CW-1:0] HOLD_LAST = CW'(HOLD - 1);

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [SW-1:0] sel_ding_q, sel_ding_d;
  logic [SW-1:0] sel_dong_q, sel_dong_d;
  logic          busy_q, busy_d;
  logic [W:0]    pipe_q [DELAY];
  logic [W:0]    pipe_d [DELAY];

  logic [SW-1:0] sel_cur;
  logic [W-1:0]  raw_tone;
  logic          raw_valid;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    sel_ding_d = sel_ding_q;
    sel_dong_d = sel_dong_q;
    case (state_q)
      IDLE: begin
        if (press) begin
          sel_ding_d = sel_ding;
          sel_dong_d = sel_dong;
          cnt_d      = '0;
          state_d    = DING;
        end
      end
      DING: begin
        if (cnt_q == HOLD_LAST) begin
          cnt_d   = '0;
          state_d = DONG;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      DONG: begin
`ifdef CHIME_RETRIGGER_EN
        if (press) begin
          sel_ding_d = sel_ding;
          sel_dong_d = sel_dong;
          cnt_d      = '0;
          state_d    = DING;
        end else
`endif
        if (cnt_q == HOLD_LAST) begin
          cnt_d   = '0;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        cnt_d   = '0;
        state_d = IDLE;
      end
    endcase
    busy_d = (state_d != IDLE);
  end

  // Selects beyond N_CH match no channel and fall through to a silent but valid tone.
  always_comb begin
    sel_cur   = (state_q == DING) ? sel_ding_q : sel_dong_q;
    raw_valid = (state_q != IDLE);
    raw_tone  = '0;
    if (raw_valid) begin
      for (int i = 0; i < N_CH; i++) begin
        if (sel_cur == SW'(i)) raw_tone = snd[i*W +: W];
      end
    end
  end

  always_comb begin
    pipe_d[0] = {raw_valid, raw_tone};
    for (int i = 1; i < DELAY; i++) pipe_d[i] = pipe_q[i-1];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      sel_ding_q <= '0;
      sel_dong_q <= '0;
      busy_q     <= 1'b0;
      for (int i = 0; i < DELAY; i++) pipe_q[i] <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      sel_ding_q <= sel_ding_d;
      sel_dong_q <= sel_dong_d;
      busy_q     <= busy_d;
      for (int i = 0; i < DELAY; i++) pipe_q[i] <= pipe_d[i];
    end
  end

  assign busy      = busy_q;
  assign out       = pipe_q[DELAY-1][W-1:0];
  assign out_valid = pipe_q[DELAY-1][W];

endmodule

// File: doc/chime_sequencer.md
Name: chime_sequencer

Overview:
- Parametrised successor of the two-input doorbell mux.
- Selects from N_CH sound sources and plays a two-note "ding-dong" sequence on a button press.
- Each note is held for HOLD cycles, and the result is delayed through a DELAY-cycle register pipeline. Delay is counted in clock cycles, not simulation ticks.
- Sits between the sound-source bank and the speaker driver.

Parameters:
- N_CH, 4: number of sound-source channels (≥2).
- W, 8: sample width per channel, in bits.
- HOLD, 16: cycles each note is held (≥1).
- DELAY, 5: output pipeline depth in cycles (≥1).
- SW, $clog2(N_CH): select width (derived; not overridden).

Ports:
- clk, input, 1: system clock, rising edge.
- rst_n, input, 1: asynchronous active-low reset.
- snd, input, N_CH*W: packed sources; channel i occupies bits [i*W+W-1 : i*W].
- sel_ding, input, SW: channel for the first note.
- sel_dong, input, SW: channel for the second note.
- press, input, 1: doorbell button, level, synchronous to clk.
- busy, output, 1: high while the FSM is not IDLE.
- out, output, W: delayed chime sample.
- out_valid, output, 1: out carries a note sample (delayed with out).

Behaviour:
- Reset (async assert, sync deassert assumed upstream):
  - State=IDLE, note counter=0, latched selects=0.
  - All DELAY pipeline stages cleared.
  - out=0, out_valid=0, busy=0.
- FSM states: IDLE, DING, DONG.
- IDLE:
  - press=1 at edge k → latch sel_ding/sel_dong, counter←0, state←DING (cycles k+1 onward).
  - press=0 → stay in IDLE.
- DING:
  - Raw tone = snd channel[latched sel_ding], raw_valid=1.
  - Counter increments each cycle. When counter==HOLD-1: counter←0, state←DONG.
- DONG:
  - Raw tone = snd channel[latched sel_dong], raw_valid=1.
  - When counter==HOLD-1: state←IDLE.
- IDLE raw tone = 0, raw_valid=0.
- Timing: press accepted at edge k →
  - DING occupies cycles k+1..k+HOLD.
  - DONG occupies cycles k+HOLD+1..k+2*HOLD.
  - IDLE from k+2*HOLD+1.
- busy = (state != IDLE), registered with state. busy does not cover pipeline drain.
- Pipeline:
  - DELAY register stages carry {raw_valid, raw tone}.
  - out/out_valid at cycle t equal the raw values from cycle t-DELAY.
  - First valid output at cycle k+1+DELAY; last at cycle k+2*HOLD+DELAY.
- Source sampling: snd is sampled live each cycle. The selected channel is fixed per note, but the sample values track the inputs.
- Out-of-range select (latched value ≥ N_CH): raw tone = 0, raw_valid stays 1.
- press while busy: ignored. Selects are not re-latched (see optional feature).
- press held continuously: after returning to IDLE, a new sequence starts on the next edge with press=1. There is one IDLE cycle between sequences.
- Reset mid-sequence: everything clears immediately. No partial note reaches out after reset.

Optional Feature:
- Macro: CHIME_RETRIGGER_EN.
- Defined:
  - press=1 while in DONG → re-latch selects, counter←0, state←DING on the next cycle.
  - press during DING is still ignored.
- Undefined: press is ignored while busy, as above.

Test Plan:
All scenarios use N_CH=4, W=8, HOLD=4, DELAY=5, with snd channels 0..3 = 8'h11, 8'h22, 8'h33, 8'h44.
1. Reset: assert rst_n=0 mid-simulation → out=0, out_valid=0, busy=0 immediately, without a clock edge.
2. Basic chime: sel_ding=1, sel_dong=3, press for 1 cycle at edge k →
   - busy high during k+1..k+8.
   - out=8'h22 with out_valid=1 during k+6..k+9.
   - out=8'h44 during k+10..k+13.
   - out_valid=0 from k+14.
3. Ignored press: press again at k+3 (macro off) → output sequence identical to scenario 2; busy falls after k+8.
4. Retrigger (CHIME_RETRIGGER_EN defined): press at k+6 with sel_ding=0 →
   - DONG is truncated after 2 cycles; state enters DING at k+7.
   - out shows 8'h44 at k+10..k+11, then 8'h11 from k+12 for 4 cycles.
5. Live source: change channel 1 from 8'h22 to 8'h55 at k+2 during DING → out is 8'h22 at k+6, then 8'h55 at k+7..k+9.
6. Reset mid-sequence: rst_n low at k+5 for 2 cycles → out_valid=0 and out=0 from assertion onward; no 8'h44 ever appears; busy=0.
